// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Front-end conditioner for board pushbuttons and switches. Every channel is
//   synchronised to Clock, normalised so that 1 means "pressed", and filtered
//   so that a level change is accepted only after STABLE_CYCLES consecutive
//   identical samples. The clean level is glitch-free and synchronous, which is
//   what the downstream single-pulse press detector expects on its input.
//
// Parameters
//   WIDTH         number of independent channels
//   STABLE_CYCLES consecutive identical samples needed to accept a change (>= 2)
//   ACTIVE_LOW    1: raw=0 means pressed, 0: raw=1 means pressed
//
// Ports
//   Clock    in   1      system clock
//   Reset    in   1      synchronous reset, active-high
//   raw      in   WIDTH  asynchronous button/switch inputs
//   clean    out  WIDTH  debounced level, 1 = pressed (registered)
//   pending  out  WIDTH  1 while a channel is qualifying a level change (registered)
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] pending
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // Level the synchronizer holds while the button is not pressed.
  localparam logic [WIDTH-1:0] RELEASED = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
    $error("key_debouncer: STABLE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_PEND_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_PEND_L = 2'd3
  } state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sample_s;

  // Two-flop synchronizer; reset parks it at the released level so no
  // spurious press is seen right after Reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Polarity normalisation: 1 always means pressed from here on.
  assign sample_s = sync2_q ^ {WIDTH{ACTIVE_LOW}};

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             pending_q;

    // Next-state logic of the per-channel qualification FSM.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_LOW: begin
          if (sample_s[g]) begin
            state_d = ST_PEND_H;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_LOW;
            cnt_d   = CNT_ZERO;
          end
        end
        ST_PEND_H: begin
          if (!sample_s[g]) begin
            // Opposite sample: glitch rejected, back to the stable level.
            state_d = ST_LOW;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PEND_H;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sample_s[g]) begin
            state_d = ST_PEND_L;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ZERO;
          end
        end
        ST_PEND_L: begin
          if (sample_s[g]) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PEND_L;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // State/counter registers plus output flops decoded from the next state,
    // so outputs are registered yet track the FSM state with no extra delay.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        state_q   <= ST_LOW;
        cnt_q     <= CNT_ZERO;
        clean_q   <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        clean_q   <= (state_d == ST_HIGH) || (state_d == ST_PEND_L);
        pending_q <= (state_d == ST_PEND_H) || (state_d == ST_PEND_L);
      end
    end

    assign clean[g]   = clean_q;
    assign pending[g] = pending_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//   Self-checking bench for key_debouncer (WIDTH=4, STABLE_CYCLES=4,
//   ACTIVE_LOW=1). A behavioural model tracks each channel as "the level flips
//   once the last STABLE_CYCLES normalised samples all disagree with it";
//   pending is "the newest sample disagrees with the current level". A
//   directed table, hand-written corner sequences and random stimulus are all
//   compared against constants and the model.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int W = 4;
  localparam int S = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] raw;
  logic [W-1:0] clean;
  logic [W-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #50 Clock = ~Clock;

  key_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(S),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .raw    (raw),
    .clean  (clean),
    .pending(pending)
  );

  // Reference model state
  logic [W-1:0] m_p1;
  logic [W-1:0] m_p2;
  logic [W-1:0] m_clean;
  logic [W-1:0] m_pend;
  logic [W-1:0] m_hist [S];

  typedef struct {
    logic         rst;
    logic [W-1:0] r;
    logic [W-1:0] exp_clean;
    logic [W-1:0] exp_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [W-1:0] r,
                              input logic [W-1:0] ec, input logic [W-1:0] ep);
    vec_t v;
    v.rst       = rst;
    v.r         = r;
    v.exp_clean = ec;
    v.exp_pend  = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge.
  task automatic model_edge(input logic rst, input logic [W-1:0] r);
    logic [W-1:0] n;
    logic         all_opp;
    if (rst) begin
      m_p1 = '1;
      m_p2 = '1;
      for (int i = 0; i < S; i++) m_hist[i] = '0;
      m_clean = '0;
      m_pend  = '0;
    end else begin
      n = ~m_p2;
      for (int i = 0; i < S - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[S-1] = n;
      for (int b = 0; b < W; b++) begin
        all_opp = 1'b1;
        for (int i = 0; i < S; i++) begin
          if (m_hist[i][b] == m_clean[b]) all_opp = 1'b0;
        end
        if (all_opp) m_clean[b] = ~m_clean[b];
        m_pend[b] = (n[b] != m_clean[b]);
      end
      m_p2 = m_p1;
      m_p1 = r;
    end
  endtask

  // Drive inputs, take one edge, sample on the falling edge and compare to the model.
  task automatic tick(input logic rst, input logic [W-1:0] r);
    Reset = rst;
    raw   = r;
    @(posedge Clock);
    model_edge(rst, r);
    @(negedge Clock);
    check("model_clean", clean, m_clean);
    check("model_pending", pending, m_pend);
  endtask

  initial begin
    logic [W-1:0] cur;
    logic         rst;

    Reset = 1'b1;
    raw   = 4'hF;
    m_p1  = '1;
    m_p2  = '1;
    m_clean = '0;
    m_pend  = '0;
    for (int i = 0; i < S; i++) m_hist[i] = '0;

    // Reset, idle, press on channel 0, short press on channel 1.
    tbl.push_back(mk(1'b1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(1'b1, 4'hF, 4'h0, 4'h0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(1'b0, 4'hE, 4'h0, 4'h0));   // E0
    tbl.push_back(mk(1'b0, 4'hE, 4'h0, 4'h0));   // E1
    tbl.push_back(mk(1'b0, 4'hE, 4'h0, 4'h1));   // E2 pending
    tbl.push_back(mk(1'b0, 4'hE, 4'h0, 4'h1));   // E3
    tbl.push_back(mk(1'b0, 4'hE, 4'h0, 4'h1));   // E4
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h0));   // E5 clean
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h0));
    tbl.push_back(mk(1'b0, 4'hC, 4'h1, 4'h0));   // raw[1] low x3
    tbl.push_back(mk(1'b0, 4'hC, 4'h1, 4'h0));
    tbl.push_back(mk(1'b0, 4'hC, 4'h1, 4'h2));
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h2));   // raw[1] back high
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h2));
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h0));   // glitch rejected
    tbl.push_back(mk(1'b0, 4'hE, 4'h1, 4'h0));

    foreach (tbl[k]) begin
      tick(tbl[k].rst, tbl[k].r);
      check($sformatf("tbl%0d_clean", k), clean, tbl[k].exp_clean);
      check($sformatf("tbl%0d_pending", k), pending, tbl[k].exp_pend);
    end

    // Release of channel 0 with a one-cycle low glitch; final rise at g=3.
    for (int g = 0; g < 9; g++) begin
      tick(1'b0, (g == 2) ? 4'hE : 4'hF);
      check($sformatf("release_glitch_g%0d", g), clean, (g >= 8) ? 4'h0 : 4'h1);
    end

    // Channel 2 pressed, then Reset pulsed while clean[2]=1.
    for (int e = 0; e < 6; e++) begin
      tick(1'b0, 4'hB);
      check($sformatf("press2_e%0d", e), clean, (e == 5) ? 4'h4 : 4'h0);
    end
    tick(1'b1, 4'hB);
    check("reset_mid_clean", clean, 4'h0);
    check("reset_mid_pending", pending, 4'h0);
    for (int e = 0; e < 7; e++) begin
      tick(1'b0, 4'hB);
      check($sformatf("after_reset_e%0d", e), clean, (e >= 5) ? 4'h4 : 4'h0);
    end

    // Release everything, then press 0 and 3 together; 3 released after 2 cycles.
    for (int e = 0; e < 8; e++) tick(1'b0, 4'hF);
    check("all_released", clean, 4'h0);
    for (int e = 0; e < 8; e++) begin
      tick(1'b0, (e < 2) ? 4'h6 : 4'hE);
      check($sformatf("dual_e%0d", e), clean, (e >= 5) ? 4'h1 : 4'h0);
    end

    // Random stimulus against the model (checked inside tick).
    cur = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ 4'($urandom_range(1, 15));
      rst = ($urandom_range(0, 99) == 0);
      tick(rst, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
